// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: the recorded fetch-time prediction
// and the mispredict rule applied at resolve time.
package bru_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // A control instruction is wrong if the direction differs or a taken target differs;
    // a non-control instruction is wrong only if fetch predicted it taken.
    function automatic logic is_mispredict(
        input pred_entry_t head,
        input logic        is_ctrl,
        input logic        taken,
        input logic [31:0] target
    );
        logic wrong;
        if (is_ctrl) begin
            wrong = (taken != head.taken) | (taken & (target != head.target));
        end else begin
            wrong = head.taken;
        end
        return wrong;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side enqueue, execute-side resolve and BTB/redirect outputs of the
// branch resolve unit, bundled as one interface.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    logic             if_fire;
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic [31:0]      if_pred_target;
    logic             fifo_full;

    logic             ex_valid;
    logic [31:0]      ex_pc;
    logic             ex_is_ctrl;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ext_flush;

    logic [31:0]      update_pc;
    logic             update;
    logic [31:0]      update_target;
    logic             mispredicted;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             sync_err;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output if_fire, if_pc, if_pred_taken, if_pred_target,
        output ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target, ext_flush,
        input  fifo_full,
        input  update_pc, update, update_target, mispredicted,
        input  redirect_valid, redirect_pc, sync_err, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_fire, if_pc, if_pred_taken, if_pred_target,
        input  ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target, ext_flush,
        output fifo_full,
        output update_pc, update, update_target, mispredicted,
        output redirect_valid, redirect_pc, sync_err, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/pred_fifo.sv
// In-order store of fetch-time predictions. Clear wins over push/pop; a push while
// full is accepted only when the head is popped on the same edge.
module pred_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t wr_data,
    output pred_entry_t rd_data,
    output logic        full,
    output logic        empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    pred_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage resolver: pairs each resolving instruction with its fetch-time prediction,
// then emits registered BTB update, pipeline redirect and statistics.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    branch_resolve_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pred_entry_t enq_entry;
    pred_entry_t head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        resolve;
    logic        hit;
    logic        mispred;
    logic        fifo_clear;
    logic        sync_fault;
    logic [31:0] next_pc;

    assign enq_entry = '{pc: bus.if_pc, taken: bus.if_pred_taken, target: bus.if_pred_target};

    // A trap flush takes priority; the resolving instruction is discarded with the rest.
    assign resolve    = bus.ex_valid & ~bus.ext_flush;
    assign hit        = resolve & ~fifo_empty;
    assign sync_fault = resolve & (fifo_empty | (head.pc != bus.ex_pc));
    assign mispred    = hit & is_mispredict(head, bus.ex_is_ctrl, bus.ex_taken, bus.ex_target);
    assign fifo_clear = bus.ext_flush | mispred;
    assign next_pc    = (bus.ex_is_ctrl & bus.ex_taken) ? bus.ex_target : bus.ex_pc + PC_STEP;

    assign bus.fifo_full = fifo_full;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.if_fire),
        .pop     (hit),
        .clear   (fifo_clear),
        .wr_data (enq_entry),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.update         <= 1'b0;
            bus.mispredicted   <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.update_pc      <= '0;
            bus.update_target  <= '0;
            bus.redirect_pc    <= '0;
            bus.sync_err       <= 1'b0;
        end else begin
            bus.update         <= hit & (bus.ex_is_ctrl | head.taken);
            bus.mispredicted   <= mispred;
            bus.redirect_valid <= mispred;
            if (hit) begin
                bus.update_pc     <= bus.ex_pc;
                bus.update_target <= bus.ex_target;
                bus.redirect_pc   <= next_pc;
            end
            if (sync_fault) bus.sync_err <= 1'b1;
        end
    end

    // Statistics saturate rather than wrap so long runs stay monotonic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.branch_cnt  <= '0;
            bus.mispred_cnt <= '0;
        end else begin
            if (hit && bus.ex_is_ctrl && (bus.branch_cnt != '1))
                bus.branch_cnt <= bus.branch_cnt + CNT_ONE;
            if (mispred && (bus.mispred_cnt != '1))
                bus.mispred_cnt <= bus.mispred_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit_if #(.CNT_W(32)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    pred_entry_t q[$];
    logic        e_update, e_mis, e_rv, e_sync;
    logic [31:0] e_upc, e_utgt, e_rpc, e_bcnt, e_mcnt;

    task automatic model_reset();
        q.delete();
        e_update = 0; e_mis = 0; e_rv = 0; e_sync = 0;
        e_upc = 0; e_utgt = 0; e_rpc = 0; e_bcnt = 0; e_mcnt = 0;
    endtask

    task automatic drive_idle();
        bus.if_fire = 0; bus.if_pc = 0; bus.if_pred_taken = 0; bus.if_pred_target = 0;
        bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_is_ctrl = 0; bus.ex_taken = 0;
        bus.ex_target = 0; bus.ext_flush = 0;
    endtask

    // Drive one cycle of inputs, advance the model, clock, and return 1ns after the edge.
    task automatic cycle(input logic fire, input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptgt, input logic ev, input logic [31:0] epc,
                         input logic ctrl, input logic tk, input logic [31:0] etgt,
                         input logic flush);
        pred_entry_t h;
        logic        cleared;
        logic        m;
        bus.if_fire = fire; bus.if_pc = pc; bus.if_pred_taken = pt; bus.if_pred_target = ptgt;
        bus.ex_valid = ev; bus.ex_pc = epc; bus.ex_is_ctrl = ctrl; bus.ex_taken = tk;
        bus.ex_target = etgt; bus.ext_flush = flush;
        e_update = 0; e_mis = 0; e_rv = 0; cleared = 0;
        if (flush) begin
            q.delete();
            cleared = 1;
        end else if (ev) begin
            if (q.size() == 0) begin
                e_sync = 1;
            end else begin
                h = q.pop_front();
                if (h.pc != epc) e_sync = 1;
                if (ctrl) m = (tk != h.taken) || (tk && (etgt != h.target));
                else      m = h.taken;
                e_update = ctrl || h.taken;
                e_mis = m; e_rv = m;
                e_upc = epc; e_utgt = etgt;
                e_rpc = (ctrl && tk) ? etgt : epc + 32'd4;
                if (ctrl && e_bcnt != 32'hFFFF_FFFF) e_bcnt = e_bcnt + 1;
                if (m && e_mcnt != 32'hFFFF_FFFF) e_mcnt = e_mcnt + 1;
                if (m) begin
                    q.delete();
                    cleared = 1;
                end
            end
        end
        if (fire && !cleared && q.size() < DEPTH)
            q.push_back('{pc: pc, taken: pt, target: ptgt});
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        cycle(1, pc, pt, ptgt, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic res(input logic [31:0] epc, input logic ctrl, input logic tk,
                       input logic [31:0] etgt);
        cycle(0, 0, 0, 0, 1, epc, ctrl, tk, etgt, 0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.update, bus.mispredicted, bus.redirect_valid, bus.sync_err, bus.fifo_full} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b required 00000",
                {bus.update, bus.mispredicted, bus.redirect_valid, bus.sync_err, bus.fifo_full});
        end
        checks++;
        if ({bus.update_pc, bus.update_target, bus.redirect_pc} !== 96'h0) begin
            errors++; $display("FAIL reset_pcs: got %h %h %h required 0",
                bus.update_pc, bus.update_target, bus.redirect_pc);
        end
        checks++;
        if ({bus.branch_cnt, bus.mispred_cnt} !== 64'h0) begin
            errors++; $display("FAIL reset_cnts: got %0d %0d required 0", bus.branch_cnt, bus.mispred_cnt);
        end
    endtask

    task automatic test_mispredict_taken();
        do_reset();
        enq(32'h000A_0000, 0, 32'h0);
        res(32'h000A_0000, 1, 1, 32'h000A_0020);
        checks++;
        if ({bus.update, bus.mispredicted, bus.redirect_valid} !== 3'b111) begin
            errors++; $display("FAIL mp_taken_flags: got %b required 111",
                {bus.update, bus.mispredicted, bus.redirect_valid});
        end
        checks++;
        if (bus.update_target !== 32'h000A_0020 || bus.redirect_pc !== 32'h000A_0020 ||
            bus.update_pc !== 32'h000A_0000) begin
            errors++; $display("FAIL mp_taken_pcs: got upc=%h utgt=%h rpc=%h required 000a0000 000a0020 000a0020",
                bus.update_pc, bus.update_target, bus.redirect_pc);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.update, bus.redirect_valid} !== 2'b00 || bus.redirect_pc !== 32'h000A_0020) begin
            errors++; $display("FAIL mp_taken_hold: got upd=%b rv=%b rpc=%h required 0 0 000a0020",
                bus.update, bus.redirect_valid, bus.redirect_pc);
        end
    endtask

    task automatic test_correct_taken();
        do_reset();
        enq(32'h000B_0000, 1, 32'h000B_0020);
        res(32'h000B_0000, 1, 1, 32'h000B_0020);
        checks++;
        if ({bus.update, bus.mispredicted, bus.redirect_valid} !== 3'b100) begin
            errors++; $display("FAIL ok_taken_flags: got %b required 100",
                {bus.update, bus.mispredicted, bus.redirect_valid});
        end
        checks++;
        if (bus.branch_cnt !== 32'd1 || bus.mispred_cnt !== 32'd0) begin
            errors++; $display("FAIL ok_taken_cnts: got %0d %0d required 1 0", bus.branch_cnt, bus.mispred_cnt);
        end
    endtask

    task automatic test_taken_not_taken();
        do_reset();
        enq(32'h000A_0000, 1, 32'h000A_0020);
        enq(32'h000A_0020, 0, 32'h0);
        res(32'h000A_0000, 1, 0, 32'h000A_0020);
        checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h000A_0004) begin
            errors++; $display("FAIL tnt_redirect: got rv=%b rpc=%h required 1 000a0004",
                bus.redirect_valid, bus.redirect_pc);
        end
        // Wrong-path entry must be gone: exactly four more enqueues fill the FIFO.
        for (int i = 0; i < 3; i++) enq(32'h0000_1000 + 32'(i * 4), 0, 0);
        checks++;
        if (bus.fifo_full !== 1'b0) begin
            errors++; $display("FAIL tnt_empty_after: got full=%b required 0 after 3 enq", bus.fifo_full);
        end
        enq(32'h0000_100C, 0, 0);
        checks++;
        if (bus.fifo_full !== 1'b1) begin
            errors++; $display("FAIL tnt_full4: got full=%b required 1", bus.fifo_full);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) enq(32'h0000_0100 + 32'(i * 4), 0, 0);
        checks++;
        if (bus.fifo_full !== 1'b1) begin
            errors++; $display("FAIL full_after4: got %b required 1", bus.fifo_full);
        end
        enq(32'h0000_0110, 0, 0);
        checks++;
        if (bus.fifo_full !== 1'b1) begin
            errors++; $display("FAIL full_drop5: got %b required 1", bus.fifo_full);
        end
        cycle(1, 32'h0000_0200, 0, 0, 1, 32'h0000_0100, 0, 0, 0, 0);
        checks++;
        if (bus.fifo_full !== 1'b1 || bus.update !== 1'b0) begin
            errors++; $display("FAIL full_enq_deq: got full=%b upd=%b required 1 0", bus.fifo_full, bus.update);
        end
        res(32'h0000_0104, 0, 0, 0);
        res(32'h0000_0108, 0, 0, 0);
        res(32'h0000_010C, 0, 0, 0);
        res(32'h0000_0200, 0, 0, 0);
        checks++;
        if (bus.sync_err !== 1'b0 || bus.fifo_full !== 1'b0) begin
            errors++; $display("FAIL full_order: got sync_err=%b full=%b required 0 0", bus.sync_err, bus.fifo_full);
        end
    endtask

    task automatic test_nonctrl();
        do_reset();
        enq(32'h000C_0000, 1, 32'h000C_0040);
        res(32'h000C_0000, 0, 0, 32'h0);
        checks++;
        if ({bus.update, bus.mispredicted} !== 2'b11 || bus.redirect_pc !== 32'h000C_0004) begin
            errors++; $display("FAIL nonctrl: got upd=%b mis=%b rpc=%h required 1 1 000c0004",
                bus.update, bus.mispredicted, bus.redirect_pc);
        end
        checks++;
        if (bus.branch_cnt !== 32'd0 || bus.mispred_cnt !== 32'd1) begin
            errors++; $display("FAIL nonctrl_cnts: got %0d %0d required 0 1", bus.branch_cnt, bus.mispred_cnt);
        end
    endtask

    task automatic test_sync_err();
        do_reset();
        res(32'h0000_4000, 1, 1, 32'h0000_5000);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.update !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            errors++; $display("FAIL sync_empty: got se=%b upd=%b rv=%b required 1 0 0",
                bus.sync_err, bus.update, bus.redirect_valid);
        end
        do_reset();
        enq(32'h0000_6000, 0, 0);
        res(32'h0000_6100, 0, 0, 0);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.update_pc !== 32'h0000_6100 || bus.redirect_pc !== 32'h0000_6104) begin
            errors++; $display("FAIL sync_pc_mismatch: got se=%b upc=%h rpc=%h required 1 00006100 00006104",
                bus.sync_err, bus.update_pc, bus.redirect_pc);
        end
    endtask

    task automatic test_ext_flush();
        do_reset();
        for (int i = 0; i < 3; i++) enq(32'h0000_7000 + 32'(i * 4), 1, 32'h0000_8000);
        cycle(0, 0, 0, 0, 1, 32'h0000_7000, 1, 0, 0, 1);
        checks++;
        if ({bus.update, bus.redirect_valid, bus.mispredicted, bus.sync_err} !== 4'b0) begin
            errors++; $display("FAIL flush_no_pulse: got %b required 0000",
                {bus.update, bus.redirect_valid, bus.mispredicted, bus.sync_err});
        end
        for (int i = 0; i < 3; i++) enq(32'h0000_9000 + 32'(i * 4), 0, 0);
        checks++;
        if (bus.fifo_full !== 1'b0) begin
            errors++; $display("FAIL flush_empty: got full=%b required 0 after 3 enq", bus.fifo_full);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enq(32'h000D_0000, 0, 0);
        enq(32'h000D_0004, 0, 0);
        res(32'h000D_0000, 1, 1, 32'h000D_0100);
        bus.ex_valid = 1; bus.ex_pc = 32'h000D_0100; bus.ex_is_ctrl = 1; bus.ex_taken = 1;
        bus.ex_target = 32'h000D_0200;
        #1 rst = 1;
        #1;
        checks++;
        if ({bus.update, bus.mispredicted, bus.redirect_valid, bus.sync_err, bus.fifo_full} !== 5'b0 ||
            {bus.update_pc, bus.update_target, bus.redirect_pc, bus.branch_cnt, bus.mispred_cnt} !== 160'h0) begin
            errors++; $display("FAIL reset_mid: got upd=%b rv=%b upc=%h rpc=%h bcnt=%0d required all 0",
                bus.update, bus.redirect_valid, bus.update_pc, bus.redirect_pc, bus.branch_cnt);
        end
        @(posedge clk);
        #1;
        drive_idle();
        rst = 0;
        model_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.update !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_pending: got upd=%b rv=%b required 0 0",
                bus.update, bus.redirect_valid);
        end
    endtask

    task automatic test_random();
        logic        fire, pt, ev, ctrl, tk, flush;
        logic [31:0] pc, ptgt, epc, etgt, base;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            fire  = ($urandom_range(0, 3) != 0);
            pc    = {16'h0010, 4'h0, 12'($urandom_range(0, 255) * 4)};
            pt    = $urandom_range(0, 1);
            ptgt  = pc + (($urandom_range(0, 1) != 0) ? 32'd16 : 32'd64);
            ev    = ($urandom_range(0, 2) != 0);
            base  = (q.size() > 0) ? q[0].pc : pc;
            epc   = ($urandom_range(0, 31) != 0) ? base : base + 32'd8;
            ctrl  = ($urandom_range(0, 3) != 0);
            tk    = ctrl ? 1'($urandom_range(0, 1)) : 1'b0;
            etgt  = base + (($urandom_range(0, 1) != 0) ? 32'd16 : 32'd64);
            flush = ($urandom_range(0, 39) == 0);
            if (n == 300) pc = 32'hFFFF_FFFC;
            cycle(fire, pc, pt, ptgt, ev, epc, ctrl, tk, etgt, flush);
            checks++;
            if ({bus.update, bus.mispredicted, bus.redirect_valid, bus.sync_err, bus.fifo_full} !==
                {e_update, e_mis, e_rv, e_sync, (q.size() == DEPTH)}) begin
                errors++; $display("FAIL rand_flags cyc %0d: got %b required %b", n,
                    {bus.update, bus.mispredicted, bus.redirect_valid, bus.sync_err, bus.fifo_full},
                    {e_update, e_mis, e_rv, e_sync, (q.size() == DEPTH)});
            end
            checks++;
            if (bus.update_pc !== e_upc || bus.update_target !== e_utgt || bus.redirect_pc !== e_rpc) begin
                errors++; $display("FAIL rand_pcs cyc %0d: got %h %h %h required %h %h %h", n,
                    bus.update_pc, bus.update_target, bus.redirect_pc, e_upc, e_utgt, e_rpc);
            end
            checks++;
            if (bus.branch_cnt !== e_bcnt || bus.mispred_cnt !== e_mcnt) begin
                errors++; $display("FAIL rand_cnts cyc %0d: got %0d %0d required %0d %0d", n,
                    bus.branch_cnt, bus.mispred_cnt, e_bcnt, e_mcnt);
            end
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_mispredict_taken();
        test_correct_taken();
        test_taken_not_taken();
        test_full();
        test_nonctrl();
        test_sync_err();
        test_ext_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
